exp_series_datapath: RTL and testbench

- Fixed-point datapath for the Taylor-series exponential unit: computes e^x ≈ Σ_{k=0}^{TERMS-1} x^k/k! for 0 ≤ x < 1.
- Sits directly downstream of the exponential control unit (IDLE/INIT/MUL/ADD/LD FSM).
- Consumes that unit's ldX, ldTmp and selTmp strobes; returns done to it.
- Holds the X register, current-term (Tmp) register, accumulator, term counter and coefficient lookup.

---
 rtl/exp_pkg.sv | 18 +
 rtl/exp_coef_rom.sv | 30 +++
 rtl/exp_series_datapath.sv | 104 ++++++++++
 tb/tb_exp_series_datapath.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/exp_pkg.sv
// Shared defaults and width helpers for the Taylor-series exponential datapath.
package exp_pkg;

  localparam int unsigned EXP_WIDTH = 16;
  localparam int unsigned EXP_FRAC  = 14;
  localparam int unsigned EXP_TERMS = 5;
  localparam int unsigned EXP_ONE   = 32'(1) << EXP_FRAC;

  // One guard bit above the data width catches accumulator overflow.
  function automatic int unsigned sat_sum_width(input int unsigned width);
    return width + 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned terms);
    return $clog2(terms + 1);
  endfunction

endpackage

// File: rtl/exp_coef_rom.sv
// Reciprocal coefficient lookup: coef[k] = floor(ONE/k), coef[0] and unused slots read 0.
module exp_coef_rom
  import exp_pkg::*;
#(
  parameter int unsigned WIDTH = EXP_WIDTH,
  parameter int unsigned FRAC  = EXP_FRAC,
  parameter int unsigned TERMS = EXP_TERMS
) (
  input  logic [cnt_width(TERMS)-1:0] cnt_i,
  output logic [WIDTH-1:0]            coef_c_o
);

  localparam int unsigned CNT_W = cnt_width(TERMS);
  localparam int unsigned DEPTH = 32'(1) << CNT_W;

  function automatic logic [WIDTH-1:0] coef_of(input int unsigned k);
    if (k == 0 || k >= TERMS) return '0;
    return WIDTH'((32'(1) << FRAC) / k);
  endfunction

  logic [WIDTH-1:0] tbl [DEPTH];

  // Table padded to a power of two so every counter value indexes a defined entry.
  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_tbl
    assign tbl[k] = coef_of(32'(k));
  end

  assign coef_c_o = tbl[cnt_i];

endmodule

// File: rtl/exp_series_datapath.sv
// Taylor-series e^x datapath: X, term, accumulator and term counter driven by the
// control unit's ldX/ldTmp/selTmp strobes.
module exp_series_datapath
  import exp_pkg::*;
#(
  parameter int unsigned WIDTH = EXP_WIDTH,
  parameter int unsigned FRAC  = EXP_FRAC,
  parameter int unsigned TERMS = EXP_TERMS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x_in,
  input  logic             ldX,
  input  logic             ldTmp,
  input  logic             selTmp,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] term,
  output logic             done
);

  localparam int unsigned CNT_W = cnt_width(TERMS);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned SUM_W = sat_sum_width(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(32'(1) << FRAC);

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] coef_c;
  logic [PW-1:0]    prod_x_c, prod_k_c;
  logic [WIDTH-1:0] p_c, nt_c, acc_sat_c;
  logic [SUM_W-1:0] sum_c;
  logic             advance_c;

  exp_coef_rom #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .TERMS (TERMS)
  ) u_coef_rom (
    .cnt_i    (cnt_q),
    .coef_c_o (coef_c)
  );

  // Next term: ((term*X)>>FRAC) * coef[cnt] >> FRAC, both steps truncating.
  always_comb begin
    prod_x_c  = PW'(term_q) * PW'(x_q);
    p_c       = WIDTH'(prod_x_c >> FRAC);
    prod_k_c  = PW'(p_c) * PW'(coef_c);
    nt_c      = WIDTH'(prod_k_c >> FRAC);
    sum_c     = SUM_W'(acc_q) + SUM_W'(nt_c);
    acc_sat_c = sum_c[SUM_W-1] ? '1 : sum_c[WIDTH-1:0];
    advance_c = ldTmp && !selTmp && !done_q && (cnt_q != '0);
  end

  // Priority: advance, then ldX (wins cnt/done), then init (wins term/acc/cnt).
  always_comb begin
    x_d    = x_q;
    term_d = term_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (advance_c) begin
      term_d = nt_c;
      acc_d  = acc_sat_c;
      cnt_d  = cnt_q + CNT_W'(1);
      done_d = ((cnt_q + CNT_W'(1)) == CNT_W'(TERMS));
    end
    if (ldX) begin
      x_d    = x_in;
      cnt_d  = '0;
      done_d = 1'b0;
    end
    if (ldTmp && selTmp) begin
      term_d = ONE;
      acc_d  = ONE;
      cnt_d  = CNT_W'(1);
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      term_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      term_q <= term_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign result = acc_q;
  assign term   = term_q;
  assign done   = done_q;

endmodule

// File: tb/tb_exp_series_datapath.sv
// Bench for exp_series_datapath: directed vector table, async reset and random strobes
// checked against an integer model of the series rules.
module tb_exp_series_datapath;

  localparam int W    = 16;
  localparam int F    = 14;
  localparam int T    = 5;
  localparam int ONE  = 1 << F;
  localparam longint MAXV = (64'd1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  x_in;
  logic          ldX, ldTmp, selTmp;
  logic [W-1:0]  result, term;
  logic          done;

  exp_series_datapath #(.WIDTH(W), .FRAC(F), .TERMS(T)) dut (
    .clk    (clk),
    .rst    (rst),
    .x_in   (x_in),
    .ldX    (ldX),
    .ldTmp  (ldTmp),
    .selTmp (selTmp),
    .result (result),
    .term   (term),
    .done   (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  longint m_x, m_term, m_acc;
  int     m_cnt;
  bit     m_done;

  typedef struct {
    bit ldx;
    bit ldt;
    bit sel;
    int xin;
    int e_term;
    int e_res;
    bit e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W-1:0] act, input longint exp);
    n_checks++;
    if ((^act === 1'bx) || (longint'(act) != exp)) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_term = 0; m_acc = 0; m_cnt = 0; m_done = 0;
  endtask

  // Series rules applied to pre-edge state; later effects override earlier ones.
  task automatic model_clock(input bit lx, input bit lt, input bit sl, input longint xi);
    longint p, nt, s;
    if (lt && !sl && !m_done && m_cnt >= 1) begin
      p  = ((m_term * m_x) >> F) & MAXV;
      nt = ((p * (ONE / m_cnt)) >> F) & MAXV;
      s  = m_acc + nt;
      m_term = nt;
      m_acc  = (s > MAXV) ? MAXV : s;
      m_cnt  = m_cnt + 1;
      m_done = (m_cnt == T);
    end
    if (lx) begin
      m_x = xi; m_cnt = 0; m_done = 0;
    end
    if (lt && sl) begin
      m_term = ONE; m_acc = ONE; m_cnt = 1; m_done = 0;
    end
  endtask

  task automatic step(input bit lx, input bit lt, input bit sl, input int xi);
    ldX = lx; ldTmp = lt; selTmp = sl; x_in = W'(xi);
    @(posedge clk);
    model_clock(lx, lt, sl, longint'(xi));
    #1;
    ldX = 1'b0; ldTmp = 1'b0; selTmp = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".term"},   term,   m_term);
    chk({tag, ".result"}, result, m_acc);
    chk({tag, ".done"},   {{(W-1){1'b0}}, done}, longint'(m_done));
  endtask

  initial begin
    rst = 1'b1; x_in = '0; ldX = 1'b0; ldTmp = 1'b0; selTmp = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.term",   term,   0);
    chk("reset.result", result, 0);
    chk("reset.done",   {{(W-1){1'b0}}, done}, 0);
    @(negedge clk) rst = 1'b0;

    // Partial run, then an asynchronous reset between clock edges.
    step(1, 0, 0, 8192);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk_model("pre_rst");
    #2 rst = 1'b1;
    #1;
    chk("async_rst.term",   term,   0);
    chk("async_rst.result", result, 0);
    chk("async_rst.done",   {{(W-1){1'b0}}, done}, 0);
    model_reset();
    @(negedge clk) rst = 1'b0;

    //            ldx ldt sel  xin   term    res  done
    vecs.push_back('{1, 0, 0, 8192,     0,     0, 0});
    vecs.push_back('{0, 1, 1,    0, 16384, 16384, 0});
    vecs.push_back('{0, 1, 0,    0,  8192, 24576, 0});
    vecs.push_back('{0, 1, 0,    0,  2048, 26624, 0});
    vecs.push_back('{0, 1, 0,    0,   341, 26965, 0});
    vecs.push_back('{0, 1, 0,    0,    42, 27007, 1});
    vecs.push_back('{0, 1, 0,    0,    42, 27007, 1});
    vecs.push_back('{0, 1, 0,    0,    42, 27007, 1});
    vecs.push_back('{0, 1, 0,    0,    42, 27007, 1});
    vecs.push_back('{0, 1, 1,    0, 16384, 16384, 0});
    vecs.push_back('{1, 1, 0,    0,  8192, 24576, 0});
    vecs.push_back('{0, 1, 0,    0,  8192, 24576, 0});
    vecs.push_back('{0, 1, 1,    0, 16384, 16384, 0});
    vecs.push_back('{0, 1, 0,    0,     0, 16384, 0});
    vecs.push_back('{0, 1, 0,    0,     0, 16384, 0});
    vecs.push_back('{0, 1, 0,    0,     0, 16384, 0});
    vecs.push_back('{0, 1, 0,    0,     0, 16384, 1});
    vecs.push_back('{1, 0, 0, 16383,    0, 16384, 0});

    foreach (vecs[i]) begin
      step(vecs[i].ldx, vecs[i].ldt, vecs[i].sel, vecs[i].xin);
      chk($sformatf("row%0d.term", i),   term,   vecs[i].e_term);
      chk($sformatf("row%0d.result", i), result, vecs[i].e_res);
      chk($sformatf("row%0d.done", i),   {{(W-1){1'b0}}, done}, longint'(vecs[i].e_done));
    end

    // x just below 1.0: truncated five-term series sums to 44369, well short of saturation.
    step(0, 1, 1, 0);
    for (int k = 0; k < T - 1; k++) step(0, 1, 0, 0);
    chk("xmax.result", result, 44369);
    chk("xmax.done",   {{(W-1){1'b0}}, done}, 1);
    chk("xmax.nosat",  {{(W-1){1'b0}}, (result != '1)}, 1);
    chk_model("xmax");

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0), int'($urandom_range(0, ONE - 1)));
      chk_model($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
